// File: rtl/fetch_pkg.sv
// Fetch-stage shared types: queue entry layout, default widths and a log2 helper.
// No logic; imported by fetch_queue and fetch_unit.
package fetch_pkg;

  localparam int FETCH_ADDR_W  = 32;
  localparam int FETCH_INSTR_W = 32;
  localparam int FETCH_DEPTH   = 4;
  localparam int FETCH_PC_STEP = 4;

  typedef struct packed {
    logic [FETCH_INSTR_W-1:0] instr;
    logic [FETCH_ADDR_W-1:0]  pc;
    logic [FETCH_ADDR_W-1:0]  pc_next;
  } fetch_entry_t;

  // Smallest r with 2**r >= n; used for pointer widths at elaboration.
  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of fetch entries: registered head, 1-cycle push-to-head, sync flush.
// Push and pop may coincide when full; the owner must never push a full queue without a pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = FETCH_DEPTH,
  parameter type entry_t = fetch_entry_t,
  localparam int PTR_W   = clog2_f(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush_i,
  input  logic           push_i,
  input  logic           pop_i,
  input  entry_t         push_dat_i,
  output entry_t         head_dat_o,
  output logic [PTR_W:0] count_o
);

  entry_t               mem_q [DEPTH];
  logic [PTR_W-1:0]     wptr_q, wptr_d;
  logic [PTR_W-1:0]     rptr_q, rptr_d;
  logic [PTR_W:0]       count_q, count_d;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) wptr_d = wptr_q + PTR_W'(1);
      if (pop_i)  rptr_d = rptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: contents are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wptr_q] <= push_dat_i;
  end

  assign head_dat_o = mem_q[rptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register + prefetch queue; head registered, redirect-to-use latency 2.
// Stalls by holding PC once DEPTH entries are queued; FETCH_MISALIGN_CHECK_EN enables misaligned-redirect check.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = FETCH_ADDR_W,
  parameter int                INSTR_W  = FETCH_INSTR_W,
  parameter int                DEPTH    = FETCH_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = FETCH_PC_STEP
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [ADDR_W-1:0]  out_pc_next,
  output logic               misalign_err
);

  localparam int                PTR_W   = clog2_f(DEPTH);
  localparam logic [PTR_W:0]    DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP_A  = ADDR_W'(PC_STEP);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_next;
  } entry_t;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] target;
  logic [PTR_W:0]    count;
  logic              push, pop;
  entry_t            push_dat, head_dat;

  assign pc_inc = pc_q + STEP_A;
  assign pop    = out_valid && out_ready;
  assign push   = !redirect && ((count < DEPTH_C) || pop);

  always_comb begin
    pc_d = pc_q;
    if (redirect)  pc_d = target;
    else if (push) pc_d = pc_inc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  localparam logic [ADDR_W-1:0] LOW_MASK = STEP_A - ADDR_W'(1);

  logic err_q, err_d;

  assign target = redirect_addr & ~LOW_MASK;
  assign err_d  = err_q || (redirect && ((redirect_addr & LOW_MASK) != '0));

  // Sticky until reset so software can poll it after the fact.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign misalign_err = err_q;
`else
  assign target       = redirect_addr;
  assign misalign_err = 1'b0;
`endif

  assign push_dat.instr   = imem_rdata;
  assign push_dat.pc      = pc_q;
  assign push_dat.pc_next = pc_inc;

  fetch_queue #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk        (clk),
    .rst        (reset),
    .flush_i    (redirect),
    .push_i     (push),
    .pop_i      (pop),
    .push_dat_i (push_dat),
    .head_dat_o (head_dat),
    .count_o    (count)
  );

  assign imem_addr   = pc_q;
  assign out_valid   = (count != '0);
  assign out_instr   = head_dat.instr;
  assign out_pc      = head_dat.pc;
  assign out_pc_next = head_dat.pc_next;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: table of per-cycle vectors plus hand sequences for reset and PC wrap.
module tb_fetch_unit;

  localparam logic [31:0] KEY = 32'hDEAD_BEEF;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam logic        MIS   = 1'b1;
  localparam logic [31:0] MIS_T = 32'h0000_0100;
`else
  localparam logic        MIS   = 1'b0;
  localparam logic [31:0] MIS_T = 32'h0000_0102;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        out_ready = 1'b0;
  logic [31:0] imem_addr, imem_rdata, out_instr, out_pc, out_pc_next;
  logic        out_valid, misalign_err;

  logic        redirect_b = 1'b0;
  logic [31:0] redirect_addr_b = '0;
  logic        out_ready_b = 1'b1;
  logic [31:0] imem_addr_b, imem_rdata_b, out_instr_b, out_pc_b, out_pc_next_b;
  logic        out_valid_b, misalign_err_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign imem_rdata   = imem_addr ^ KEY;
  assign imem_rdata_b = imem_addr_b ^ KEY;

  fetch_unit u_dut (
    .clk           (clk),
    .reset         (reset),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_pc_next   (out_pc_next),
    .misalign_err  (misalign_err)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
    .clk           (clk),
    .reset         (reset),
    .redirect      (redirect_b),
    .redirect_addr (redirect_addr_b),
    .imem_addr     (imem_addr_b),
    .imem_rdata    (imem_rdata_b),
    .out_valid     (out_valid_b),
    .out_ready     (out_ready_b),
    .out_instr     (out_instr_b),
    .out_pc        (out_pc_b),
    .out_pc_next   (out_pc_next_b),
    .misalign_err  (misalign_err_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rd;
    logic [31:0] ra;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
    logic        emis;
  } vec_t;

  localparam int NV = 24;
  vec_t tbl [NV];

  initial begin
    // Inputs apply before an edge; expectations hold in the cycle after it.
    tbl[0]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h0,   32'h4,   1'b0};
    tbl[1]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h0,   32'h8,   1'b0};
    tbl[2]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h0,   32'hC,   1'b0};
    for (int i = 3; i < 10; i++)
      tbl[i] = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h0,   32'h10,  1'b0};
    tbl[10] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   32'h14,  1'b0};
    tbl[11] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h8,   32'h18,  1'b0};
    tbl[12] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'hC,   32'h1C,  1'b0};
    tbl[13] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h10,  32'h20,  1'b0};
    tbl[14] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h14,  32'h24,  1'b0};
    tbl[15] = '{1'b1, 32'h100, 1'b1, 1'b0, 32'h0,   32'h100, 1'b0};
    tbl[16] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 32'h104, 1'b0};
    tbl[17] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h104, 32'h108, 1'b0};
    tbl[18] = '{1'b1, 32'h200, 1'b0, 1'b0, 32'h0,   32'h200, 1'b0};
    tbl[19] = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h200, 32'h204, 1'b0};
    tbl[20] = '{1'b1, 32'h102, 1'b1, 1'b0, 32'h0,   MIS_T,   MIS};
    tbl[21] = '{1'b0, 32'h0,   1'b1, 1'b1, MIS_T,   MIS_T + 32'h4, MIS};
    tbl[22] = '{1'b1, 32'h300, 1'b1, 1'b0, 32'h0,   32'h300, MIS};
    tbl[23] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h300, 32'h304, MIS};

    // Reset state
    @(negedge clk);
    chk("rst_valid",      32'(out_valid), 32'h0);
    chk("rst_imem_addr",  imem_addr, 32'h0);
    chk("rst_misalign",   32'(misalign_err), 32'h0);
    chk("rst_wrap_addr",  imem_addr_b, 32'hFFFF_FFF8);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      redirect      = tbl[i].rd;
      redirect_addr = tbl[i].ra;
      out_ready     = tbl[i].rdy;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("row%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("row%0d_imem_addr", i), imem_addr, tbl[i].eaddr);
      chk($sformatf("row%0d_misalign", i), 32'(misalign_err), 32'(tbl[i].emis));
      if (tbl[i].ev) begin
        chk($sformatf("row%0d_pc", i), out_pc, tbl[i].epc);
        chk($sformatf("row%0d_pc_next", i), out_pc_next, tbl[i].epc + 32'h4);
        chk($sformatf("row%0d_instr", i), out_instr, tbl[i].epc ^ KEY);
      end
    end

    // Asynchronous reset mid-stream, coinciding with a redirect request
    redirect      = 1'b1;
    redirect_addr = 32'h500;
    out_ready     = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid",      32'(out_valid), 32'h0);
    chk("arst_imem_addr",  imem_addr, 32'h0);
    chk("arst_misalign",   32'(misalign_err), 32'h0);
    chk("arst_wrap_valid", 32'(out_valid_b), 32'h0);
    chk("arst_wrap_addr",  imem_addr_b, 32'hFFFF_FFF8);
    @(posedge clk);
    @(negedge clk);
    redirect = 1'b0;
    chk("arst_hold_addr",  imem_addr, 32'h0);
    chk("arst_hold_valid", 32'(out_valid), 32'h0);
    reset = 1'b0;

    // Restart from RESET_PC on both instances, including the 32-bit wrap
    for (int k = 0; k < 3; k++) begin
      logic [31:0] pa, pb;
      pa = 32'(k) * 32'h4;
      pb = 32'hFFFF_FFF8 + 32'(k) * 32'h4;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("run%0d_valid", k), 32'(out_valid), 32'h1);
      chk($sformatf("run%0d_pc", k), out_pc, pa);
      chk($sformatf("run%0d_instr", k), out_instr, pa ^ KEY);
      chk($sformatf("wrap%0d_valid", k), 32'(out_valid_b), 32'h1);
      chk($sformatf("wrap%0d_pc", k), out_pc_b, pb);
      chk($sformatf("wrap%0d_pc_next", k), out_pc_next_b, pb + 32'h4);
      chk($sformatf("wrap%0d_instr", k), out_instr_b, pb ^ KEY);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch stage with a prefetch queue and a valid/ready output handshake. Holds the program counter, reads the instruction memory combinationally at the current PC, and buffers up to DEPTH fetched entries (instruction, PC, PC+step) so that decode stalls do not lose fetches. A redirect input (branch/jump target) flushes the queue and reloads the PC. Sits between the instruction memory and the decode stage; it is the successor to the free-running single-PC fetch path.

## Interface
- ADDR_W, 32, PC/address width
- INSTR_W, 32, instruction width
- DEPTH, 4, prefetch queue entries (power of two, ≥2)
- RESET_PC, 0, PC value loaded on reset
- PC_STEP, 4, PC increment per fetch
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- redirect  in  1  load redirect_addr into PC and flush queue
- redirect_addr  in  ADDR_W  redirect target
- imem_addr  out  ADDR_W  instruction-memory address (= current PC)
- imem_rdata  in  INSTR_W  instruction at imem_addr, same cycle (combinational memory)
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head
- out_instr  out  INSTR_W  head instruction
- out_pc  out  ADDR_W  head PC
- out_pc_next  out  ADDR_W  head PC + PC_STEP
- misalign_err  out  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- Queue entry = {instr, pc, pc_next}; head drives out_*; out_valid = (count != 0).
- Pop: out_valid && out_ready at rising edge.
- Push condition: !redirect && (count < DEPTH || pop). Push writes {imem_rdata, pc, pc+PC_STEP}; pc <= pc+PC_STEP. Without push, pc holds.
- Full with simultaneous pop: push and pop in the same cycle, count unchanged.
- Redirect (highest priority): count <= 0, pc <= redirect_addr, no push. Any pop that cycle is still a completed transfer from decode's view; its entry is discarded with the flush.
- Arithmetic: pc+PC_STEP modulo 2^ADDR_W; 0xFFFFFFFC+4 wraps to 0 with no flag.
- Reset (any time, including mid-stall or mid-redirect): pc = RESET_PC, count = 0, read/write pointers = 0, out_valid = 0, misalign_err = 0. out_instr/out_pc/out_pc_next are don't-care while out_valid = 0. imem_addr = RESET_PC.
- out_* are registered (queue storage); no combinational path from imem_rdata or redirect to out_*.

## Timing
- After reset deasserts: first push at first rising edge; out_valid = 1 from the following cycle with out_pc = RESET_PC.
- Steady state with out_ready = 1: one instruction per cycle, out_pc advancing by PC_STEP.
- Redirect sampled at edge N: out_valid = 0 in cycle N+1; target fetched at edge N+1; out_valid = 1 with out_pc = target in cycle N+2 (redirect-to-use latency 2).
- Backpressure: with out_ready = 0, exactly DEPTH entries fill, then imem_addr holds at RESET_PC + DEPTH·PC_STEP.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined: on redirect with redirect_addr mod PC_STEP ≠ 0 (PC_STEP a power of two), the PC loads redirect_addr with its low log2(PC_STEP) bits cleared, and misalign_err sets and stays 1 until reset.
- Undefined: redirect_addr loaded unmodified; misalign_err tied to 0.

## Structure
- Package fetch_pkg: fetch_entry_t struct {instr, pc, pc_next}, default parameter constants, and a log2 helper for the pointer width.
- Sub-module fetch_queue: DEPTH-entry FIFO of fetch_entry_t with synchronous flush, simultaneous push/pop, and count output. fetch_unit keeps the PC register, push control, redirect, and misalign logic.

## Test plan
- Reset, out_ready = 1, imem_rdata = f(addr) → imem_addr = 0 during reset; out_pc sequence 0x0, 0x4, 0x8…, out_pc_next = out_pc + 4, out_instr = f(out_pc).
- out_ready = 0 for 10 cycles after reset → 4 entries queued, imem_addr holds 0x10, out_pc stays 0x0; out_ready = 1 → 0x0, 0x4, 0x8, 0xC, 0x10 consecutively with no bubble.
- Queue full, redirect = 1 to 0x100 → out_valid = 0 next cycle, then out_pc = 0x100, 0x104; no stale entry appears.
- RESET_PC = 0xFFFFFFF8 → out_pc 0xFFFFFFF8, 0xFFFFFFFC, 0x0; out_pc_next of 0xFFFFFFFC = 0x0.
- Redirect in the same cycle as pop, then reset asserted mid-stream → flush honoured; on reset, out_valid = 0 immediately (asynchronously) and imem_addr = RESET_PC.
- With FETCH_MISALIGN_CHECK_EN: redirect to 0x102 → out_pc = 0x100 and misalign_err = 1, held after a later aligned redirect. Without the macro: out_pc = 0x102 and misalign_err = 0.
